uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It watches the receiver's level-style `rx_ready` flag and captures each completed byte exactly once. It then holds `rx_ready_clear` until the receiver drops `rx_ready`, and offers the bytes to the host logic through a first-word-fall-through FIFO with a sticky overrun flag.

## Interface
- `DEPTH_LOG2`, default 4: FIFO holds 2^DEPTH_LOG2 bytes (16).
- `sys_clk` in 1: system clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: byte from the receiver; valid while `rx_ready`=1.
- `rx_ready` in 1: receiver byte-available flag, a level held until cleared.
- `rx_ready_clear` out 1: registered request to the receiver to drop `rx_ready`.
- `rd_en` in 1: pop request from the consumer.
- `rd_data` out 8: head byte; valid whenever `empty`=0.
- `empty` out 1: FIFO holds no bytes.
- `full` out 1: FIFO holds 2^DEPTH_LOG2 bytes.
- `count` out DEPTH_LOG2+1: number of stored bytes.
- `overrun` out 1: sticky flag; a byte was dropped because the FIFO was full.
- `overrun_clear` in 1: clears `overrun`.

## Operation
- Capture FSM, two states: IDLE and CLEAR.
  - IDLE, `rx_ready`=1: push `rx_data` if the FIFO can accept it, otherwise set `overrun` and drop the byte. Set `rx_ready_clear`<=1 and go to CLEAR.
  - CLEAR: hold `rx_ready_clear`=1 until `rx_ready` is sampled 0, then set `rx_ready_clear`<=0 and go to IDLE.
  - No push ever happens in CLEAR, so each `rx_ready` assertion yields exactly one push or one overrun.
  - The receiver honours the clear only on its `rx_clk_en` ticks, so CLEAR can last many cycles. This is legal and has no timeout.
- Storage:
  - Circular buffer of 2^DEPTH_LOG2 x 8 bits.
  - Write and read pointers are DEPTH_LOG2 bits wide and wrap modulo depth.
  - `count` is a separate register.
- Push acceptance: accept when `full`=0, or when `full`=1 and a pop occurs in the same cycle.
- Pop: occurs when `rd_en`=1 and `empty`=0. `rd_en` while empty is ignored; pointers and `count` are unchanged and no flag is raised.
- Count update:
  - Push and pop in the same cycle: `count` unchanged, both pointers advance.
  - Push only: +1. Pop only: −1.
- `rd_data` = mem[rd_ptr], combinational from the storage array. Its value is don't-care while `empty`=1.
- `empty` = (`count`==0). `full` = (`count`==2^DEPTH_LOG2).
- `overrun` set and `overrun_clear` in the same cycle: set wins (`overrun` stays 1).
- Reset (`rst_n`=0, asynchronous, any time including mid-CLEAR):
  - State goes to IDLE.
  - `rx_ready_clear`=0, pointers=0, `count`=0, `empty`=1, `full`=0, `overrun`=0.
  - Storage contents are not reset.
  - The receiver is not reset by this block. If `rx_ready` is still 1 after `rst_n` deasserts, that byte is captured as a new byte.

## Timing
- Capture latency:
  - `rx_ready` sampled 1 in IDLE at edge E: the byte is written at E.
  - `empty` falls and `count` increments after E.
  - `rx_data` appears on `rd_data` in the cycle after E if the FIFO was empty.
  - `rx_ready_clear` is high from E to the edge where `rx_ready`=0 is sampled, then low the following cycle.
- Pop latency: `rd_en`=1 with `empty`=0 at edge E advances the head. The next byte, or `empty`=1, is visible after E.
- Outputs `rx_ready_clear`, `empty`, `full`, `count` and `overrun` are all registered or derived from registered state. No combinational path runs from `rx_ready` or `rd_en` to any output.
- Minimum spacing between captures is 2 cycles: IDLE→CLEAR→IDLE with `rx_ready` low for at least 1 sample.

## Test plan
- Single byte, fast clear:
  - Stimulus: after reset, raise `rx_ready` with `rx_data`=0x5A; the model drops `rx_ready` 1 cycle after `rx_ready_clear` rises.
  - Response: `count`=1, `rd_data`=0x5A, `empty`=0. `rx_ready_clear` pulses for 2 cycles and returns to 0.
- Slow clear:
  - Stimulus: hold `rx_ready`=1 for 40 cycles after `rx_ready_clear` rises (rx_clk_en-gated model).
  - Response: exactly one push (`count`=1); `rx_ready_clear` stays 1 the whole time.
- Fill, overrun and recover:
  - Stimulus: push bytes 0x00..0x10 (17 bytes), then `overrun_clear`.
  - Response: `full`=1 at 16 bytes; the 17th byte is dropped and sets `overrun`=1. `overrun_clear` then returns `overrun` to 0.
  - Draining reads 0x00..0x0F in order, and `empty`=1 afterwards.
- Simultaneous push and pop at full:
  - Stimulus: with 16 bytes stored, `rd_en`=1 in the same cycle as a capture of 0xC3.
  - Response: `count` stays 16, `overrun`=0, and 0xC3 is read last.
- Wrap-around:
  - Stimulus: 40 interleaved pushes and pops with random data.
  - Response: output order matches input order and `count` never exceeds 16.
- Pop on empty:
  - Stimulus: `rd_en` held while `empty`=1.
  - Response: `count` stays 0 and the pointers do not move; a following push reads back correctly.
- Reset mid-CLEAR:
  - Stimulus: assert `rst_n`=0 while in CLEAR with `count`=3.
  - Response: outputs immediately go to `rx_ready_clear`=0, `count`=0, `empty`=1. If `rx_ready` is still 1 after release, it is captured once.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// ============================================================================
//  Module      : uart_rx_fifo_if
//  Description : Receiver-side handshake plus host-side FIFO port of the
//                uart_rx_fifo buffer, bundled as one interface.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  // receiver side
  logic [7:0]          rx_data;
  logic                rx_ready;
  logic                rx_ready_clear;
  // host side
  logic                rd_en;
  logic [7:0]          rd_data;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] count;
  logic                overrun;
  logic                overrun_clear;

  // master: receiver model plus host consumer driving the buffer
  modport master (
    output rx_data, rx_ready, rd_en, overrun_clear,
    input  rx_ready_clear, rd_data, empty, full, count, overrun
  );

  // slave: the buffer itself
  modport slave (
    input  rx_data, rx_ready, rd_en, overrun_clear,
    output rx_ready_clear, rd_data, empty, full, count, overrun
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Captures each byte flagged by the UART receiver's level-style
//                rx_ready exactly once, requests the flag be cleared, and
//                buffers the bytes in a first-word-fall-through FIFO with a
//                sticky overrun flag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  uart_rx_fifo_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]            state;
  logic                  rx_ready_clear;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overrun;
  logic [7:0]            mem [DEPTH];

  logic                  is_empty;
  logic                  is_full;
  logic                  capture;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign is_empty = (count == '0);
  assign is_full  = (count == FULL_COUNT);

  // A capture is only ever taken in IDLE, so one rx_ready assertion gives
  // exactly one push or one overrun no matter how long CLEAR lasts.
  assign capture = (state == S_IDLE) && bus.rx_ready;
  assign pop     = bus.rd_en && !is_empty;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push    = capture && (!is_full || pop);
  assign drop    = capture && is_full && !pop;

  // Capture FSM: request the clear on capture, hold it until rx_ready drops.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      rx_ready_clear <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.rx_ready) begin
            rx_ready_clear <= 1'b1;
            state          <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (!bus.rx_ready) begin
            rx_ready_clear <= 1'b0;
            state          <= S_IDLE;
          end
        end
        default: begin
          rx_ready_clear <= 1'b0;
          state          <= S_IDLE;
        end
      endcase
    end
  end

  // Storage array write; contents deliberately survive reset.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.rx_data;
    end
  end

  // Pointers and occupancy count; pointers wrap naturally at DEPTH.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Sticky overrun; a new drop wins over a simultaneous clear.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (bus.overrun_clear) begin
      overrun <= 1'b0;
    end
  end

  assign bus.rx_ready_clear = rx_ready_clear;
  assign bus.rd_data        = mem[rd_ptr];
  assign bus.empty          = is_empty;
  assign bus.full           = is_full;
  assign bus.count          = count;
  assign bus.overrun        = overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Directed self-checking bench for uart_rx_fifo with a
//                receiver model that honours rx_ready_clear after a
//                programmable delay and a queue model of the FIFO contents.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic sys_clk;
  logic rst_n;

  uart_rx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int        n_tests = 0;
  int        n_fail  = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one rising edge and settle past it
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Receiver model: present a byte, wait for the clear request, keep rx_ready
  // high for 'hold' more edges, then drop it and wait for the clear to end.
  task automatic send_byte(input logic [7:0] d, input int hold, input logic with_pop,
                           output int hi_cycles);
    logic       do_push;
    logic [7:0] head;
    int         t;
    hi_cycles = 0;
    bus.rx_data  = d;
    bus.rx_ready = 1'b1;
    bus.rd_en    = with_pop;
    do_push = (exp_q.size() < DEPTH) || (with_pop && exp_q.size() > 0);
    if (with_pop && exp_q.size() > 0) begin
      head = exp_q.pop_front();
      check("pop_head", {24'd0, bus.rd_data}, {24'd0, head});
    end
    step();
    bus.rd_en = 1'b0;
    if (do_push) exp_q.push_back(d);
    else         exp_ovr = 1'b1;
    check("clr_rise", {31'd0, bus.rx_ready_clear}, 32'd1);
    if (bus.rx_ready_clear) hi_cycles++;
    for (int i = 0; i < hold; i++) begin
      step();
      if (bus.rx_ready_clear) hi_cycles++;
    end
    bus.rx_ready = 1'b0;
    t = 0;
    step();
    while (bus.rx_ready_clear && t < 50) begin
      hi_cycles++;
      step();
      t++;
    end
    check("clr_fall", {31'd0, bus.rx_ready_clear}, 32'd0);
    check("count", {27'd0, bus.count}, exp_q.size());
    check("overrun", {31'd0, bus.overrun}, {31'd0, exp_ovr});
  endtask

  task automatic pop_one();
    logic [7:0] head;
    check("nonempty", {31'd0, bus.empty}, 32'd0);
    head = exp_q.pop_front();
    check("rd_data", {24'd0, bus.rd_data}, {24'd0, head});
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check("count_pop", {27'd0, bus.count}, exp_q.size());
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      pop_one();
      guard++;
    end
    check("drained", {31'd0, bus.empty}, 32'd1);
  endtask

  int         hi;
  logic [7:0] rnd;

  initial begin
    bus.rx_data       = 8'h00;
    bus.rx_ready      = 1'b0;
    bus.rd_en         = 1'b0;
    bus.overrun_clear = 1'b0;
    rst_n             = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // reset state
    check("rst_clr",   {31'd0, bus.rx_ready_clear}, 32'd0);
    check("rst_count", {27'd0, bus.count}, 32'd0);
    check("rst_empty", {31'd0, bus.empty}, 32'd1);
    check("rst_full",  {31'd0, bus.full}, 32'd0);
    check("rst_ovr",   {31'd0, bus.overrun}, 32'd0);

    // single byte, fast clear: clear pulse is exactly 2 cycles
    send_byte(8'h5A, 1, 1'b0, hi);
    check("fast_hi", hi, 32'd2);
    check("fast_data", {24'd0, bus.rd_data}, 32'h5A);
    check("fast_empty", {31'd0, bus.empty}, 32'd0);
    drain();

    // slow clear: one push only, clear held throughout
    send_byte(8'h3C, 40, 1'b0, hi);
    check("slow_hi", hi, 32'd41);
    check("slow_count", {27'd0, bus.count}, 32'd1);
    drain();

    // fill to 16, overrun on the 17th, then clear the flag
    for (int i = 0; i <= 16; i++) begin
      send_byte(i[7:0], 1, 1'b0, hi);
      if (i == 15) check("full_at16", {31'd0, bus.full}, 32'd1);
    end
    check("ovr_set", {31'd0, bus.overrun}, 32'd1);
    check("ovr_count", {27'd0, bus.count}, 32'd16);
    bus.overrun_clear = 1'b1;
    step();
    bus.overrun_clear = 1'b0;
    exp_ovr = 1'b0;
    check("ovr_clr", {31'd0, bus.overrun}, 32'd0);
    check("fill_head", {24'd0, bus.rd_data}, 32'h00);
    drain();

    // simultaneous push and pop at full
    for (int i = 0; i < 16; i++) send_byte(8'hB0 + i[7:0], 1, 1'b0, hi);
    send_byte(8'hC3, 1, 1'b1, hi);
    check("pp_count", {27'd0, bus.count}, 32'd16);
    check("pp_ovr", {31'd0, bus.overrun}, 32'd0);
    while (exp_q.size() > 1) pop_one();
    check("pp_last", {24'd0, bus.rd_data}, 32'hC3);
    drain();

    // wrap-around with interleaved pushes and pops
    for (int i = 0; i < 40; i++) begin
      rnd = 8'($urandom_range(0, 255));
      send_byte(rnd, 1, 1'b0, hi);
      if (i % 4 != 0) pop_one();
      if (bus.count > 5'd16) check("wrap_bound", {27'd0, bus.count}, 32'd16);
    end
    check("wrap_ovr", {31'd0, bus.overrun}, 32'd0);
    drain();

    // pop on empty is ignored
    bus.rd_en = 1'b1;
    repeat (5) step();
    bus.rd_en = 1'b0;
    check("pe_count", {27'd0, bus.count}, 32'd0);
    check("pe_empty", {31'd0, bus.empty}, 32'd1);
    send_byte(8'h77, 1, 1'b0, hi);
    check("pe_data", {24'd0, bus.rd_data}, 32'h77);
    drain();

    // reset in the middle of CLEAR with three bytes stored
    send_byte(8'h11, 1, 1'b0, hi);
    send_byte(8'h22, 1, 1'b0, hi);
    bus.rx_data  = 8'h33;
    bus.rx_ready = 1'b1;
    step();
    check("mid_clr", {31'd0, bus.rx_ready_clear}, 32'd1);
    check("mid_count", {27'd0, bus.count}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_clr",   {31'd0, bus.rx_ready_clear}, 32'd0);
    check("ar_count", {27'd0, bus.count}, 32'd0);
    check("ar_empty", {31'd0, bus.empty}, 32'd1);
    exp_q.delete();
    exp_ovr = 1'b0;
    bus.rx_data = 8'hA5;
    repeat (2) step();
    #2;
    rst_n = 1'b1;
    // rx_ready is still high: captured once as a fresh byte
    send_byte(8'hA5, 1, 1'b0, hi);
    check("ar_recap_cnt", {27'd0, bus.count}, 32'd1);
    check("ar_recap_dat", {24'd0, bus.rd_data}, 32'hA5);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
